// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache fills, D-cache fills and D-cache write-through stores.
// Latency: first read issued the cycle after the grant; each word returns MEM_LATENCY cycles after its issue.
// Backpressure: requests are level-held and wait in IDLE; waitForICACHE holds the D side during I fills.
module cache_mem_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss_req,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss_req,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_wr_ack,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              waitForICACHE,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, WRITE} state_t;

    typedef struct packed {
        logic       vld;
        logic       own;   // 0 = I-cache, 1 = D-cache
        logic [2:0] word;
    } tag_t;

    localparam logic [3:0] BEATS     = 4'(WORDS_PER_BLOCK);
    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-5:0] base_q, base_nx;
    logic              iss_own, own_nx;
    logic [2:0]        iss_word, word_nx;
    logic              en_nx, wr_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;
    tag_t              pipe [MEM_LATENCY];
    tag_t              tail;
    logic              fill_last;
    logic              unused_addr_bits;

    assign tail             = pipe[MEM_LATENCY-1];
    assign fill_last        = tail.vld && (tail.word == LAST_WORD);
    assign fill_data        = mem_rdata;
    assign unused_addr_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A fill only leaves its state once its last word is back, so nothing else is granted meanwhile.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_miss_req)      state_nx = I_FILL;
                else if (d_miss_req) state_nx = D_FILL;
                else if (d_wr_req)   state_nx = WRITE;
            end
            I_FILL, D_FILL: if (fill_last) state_nx = IDLE;
            WRITE:          state_nx = IDLE;
            default:        state_nx = IDLE;
        endcase
    end

    always_comb begin
        en_nx         = 1'b0;
        wr_nx         = 1'b0;
        addr_nx       = '0;
        wdata_nx      = '0;
        own_nx        = 1'b0;
        word_nx       = 3'd0;
        cnt_nx        = cnt;
        base_nx       = base_q;
        d_wr_ack      = (state == WRITE);
        waitForICACHE = rst_n && ((state == I_FILL) || ((state == IDLE) && i_miss_req));
        i_data_valid  = tail.vld && !tail.own;
        d_data_valid  = tail.vld && tail.own;
        i_fill_done   = fill_last && !tail.own;
        d_fill_done   = fill_last && tail.own;
        fill_word     = tail.word;
        case (state)
            IDLE: begin
                // The grant cycle already registers beat 0 of a fill.
                if (i_miss_req || d_miss_req) begin
                    base_nx = i_miss_req ? i_miss_addr[ADDR_W-1:4] : d_miss_addr[ADDR_W-1:4];
                    en_nx   = 1'b1;
                    addr_nx = {base_nx, 4'b0000};
                    own_nx  = !i_miss_req;
                    cnt_nx  = 4'd1;
                end else if (d_wr_req) begin
                    en_nx    = 1'b1;
                    wr_nx    = 1'b1;
                    addr_nx  = d_wr_addr;
                    wdata_nx = d_wr_data;
                end
            end
            I_FILL, D_FILL: begin
                if (cnt < BEATS) begin
                    en_nx   = 1'b1;
                    addr_nx = {base_q, cnt[2:0], 1'b0};
                    word_nx = cnt[2:0];
                    own_nx  = (state == D_FILL);
                    cnt_nx  = cnt + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            base_q    <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iss_own   <= 1'b0;
            iss_word  <= 3'd0;
            for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
        end else begin
            cnt       <= cnt_nx;
            base_q    <= base_nx;
            mem_en    <= en_nx;
            mem_wr    <= wr_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            iss_own   <= own_nx;
            iss_word  <= word_nx;
            // Stage 0 captures the read visible on the port now, so the tail lines up with mem_rdata.
            pipe[0]   <= '{vld: mem_en && !mem_wr, own: iss_own, word: iss_word};
            for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

endmodule
